// File: rtl/btn_event_sched_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_sched_pkg
//
// Shared definitions for the button event scheduler:
//   - state_t     : arbiter/offer FSM state encoding (IDLE=0, OFFER=1)
//   - DEF_N_BTN   : default number of button-filter channels
//   - DEF_PRESC   : default clock cycles per sample-enable strobe
//   - clog2_min1  : ceil(log2(value)) clamped to a minimum of 1, used to size
//                   the event index so that two channels still get one bit
// -----------------------------------------------------------------------------
package btn_event_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int DEF_N_BTN = 4;
    localparam int DEF_PRESC = 250;

    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/btn_event_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// btn_event_sched_rr_arbiter
//
// Purely combinational round-robin selector. Starting at index ptr and
// walking upward with wrap-around modulo N, it returns the first requesting
// index. The wrap is an explicit subtraction of N, so non-power-of-two
// channel counts never produce an index >= N.
//
// Ports:
//   req       in  N    request vector (one bit per channel)
//   ptr       in  IDW  highest-priority index for this search (must be < N)
//   grant     out IDW  selected index (0 when nothing is requested)
//   any_grant out 1    at least one request present
// -----------------------------------------------------------------------------
module btn_event_sched_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] grant,
    output logic           any_grant
);

    // Candidate index for each search offset, wrapped into 0..N-1.
    logic [IDW-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum       = {1'b0, ptr} + (IDW+1)'(gi);
            assign cand[gi]  = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N))
                                                    : sum[IDW-1:0];
        end
    endgenerate

    // Walk offsets from the farthest to the nearest so that the nearest
    // requesting candidate (lowest offset from ptr) is the last assignment.
    always_comb begin
        grant     = '0;
        any_grant = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant = cand[k];
            end
        end
    end

endmodule

// File: rtl/btn_event_sched.sv
// -----------------------------------------------------------------------------
// btn_event_sched
//
// Controller for a bank of button-filter channels. It generates the shared
// sample-enable strobe for all filters, latches each filter's one-cycle press
// pulse into a pending bit, and serialises pending presses into a single
// valid/ready event stream using round-robin arbitration.
//
// Ports:
//   CLK       in  1      system clock, rising edge
//   RST       in  1      synchronous active-low reset
//   CE_O      out 1      one-cycle sample strobe every PRESC cycles
//   BTN_EV    in  N_BTN  press pulses from the filters
//   EV_VALID  out 1      an event is offered on EV_ID
//   EV_ID     out IDW    index of the offered button
//   EV_READY  in  1      consumer accepts the offered event
//   OVF       out N_BTN  sticky per-channel "press lost" flags
//   OVF_CLR   in  1      clears all OVF bits
// -----------------------------------------------------------------------------
module btn_event_sched
    import btn_event_sched_pkg::*;
#(
    parameter int N_BTN = DEF_N_BTN,
    parameter int PRESC = DEF_PRESC,
    parameter int IDW   = clog2_min1(N_BTN)
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             CE_O,
    input  logic [N_BTN-1:0] BTN_EV,
    output logic             EV_VALID,
    output logic [IDW-1:0]   EV_ID,
    input  logic             EV_READY,
    output logic [N_BTN-1:0] OVF,
    input  logic             OVF_CLR
);

    // ------------------------------------------------------------------
    // Prescaler: counts 0..PRESC-1. The strobe is registered from the
    // terminal count, so it appears in the cycle after the counter sits at
    // PRESC-1. With PRESC=1 the terminal count is always true and the
    // strobe stays high after the first non-reset edge.
    // ------------------------------------------------------------------
    localparam logic [15:0] PRESC_LAST = 16'(PRESC - 1);

    logic [15:0] presc_cnt_reg;
    logic        ce_reg;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            presc_cnt_reg <= '0;
            ce_reg        <= 1'b0;
        end else begin
            if (presc_cnt_reg == PRESC_LAST) begin
                presc_cnt_reg <= '0;
            end else begin
                presc_cnt_reg <= presc_cnt_reg + 16'd1;
            end
            ce_reg <= (presc_cnt_reg == PRESC_LAST);
        end
    end

    assign CE_O = ce_reg;

    // ------------------------------------------------------------------
    // Event FSM registers (declared here because the pending logic needs
    // the handshake).
    // ------------------------------------------------------------------
    state_t         state_reg;
    logic           ev_valid_reg;
    logic [IDW-1:0] ev_id_reg;
    logic [IDW-1:0] ptr_reg;

    logic handshake;
    assign handshake = ev_valid_reg & EV_READY;

    // ------------------------------------------------------------------
    // Pending and overflow bits.
    // A press on a bit that is being cleared by this cycle's handshake
    // re-arms it (set wins) and is not an overflow. A press on a bit that
    // stays pending is dropped and flagged. A fresh overflow beats OVF_CLR.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] pend_reg;
    logic [N_BTN-1:0] pend_next;
    logic [N_BTN-1:0] ovf_reg;
    logic [N_BTN-1:0] ovf_next;
    logic [N_BTN-1:0] clr_vec;
    logic [N_BTN-1:0] ovf_set;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            assign clr_vec[gi]   = handshake && (ev_id_reg == IDW'(gi));
            assign ovf_set[gi]   = BTN_EV[gi] & pend_reg[gi] & ~clr_vec[gi];
            assign pend_next[gi] = BTN_EV[gi] | (pend_reg[gi] & ~clr_vec[gi]);
            assign ovf_next[gi]  = ovf_set[gi] | (ovf_reg[gi] & ~OVF_CLR);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pend_reg <= '0;
            ovf_reg  <= '0;
        end else begin
            pend_reg <= pend_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign OVF = ovf_reg;

    // ------------------------------------------------------------------
    // Round-robin selection over the registered pending vector.
    // ------------------------------------------------------------------
    logic [IDW-1:0] grant;
    logic           any_grant;

    btn_event_sched_rr_arbiter #(
        .N   (N_BTN),
        .IDW (IDW)
    ) u_rr_arbiter (
        .req       (pend_reg),
        .ptr       (ptr_reg),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // Pointer advances to the slot after the accepted event, wrapping
    // explicitly at N_BTN-1.
    logic [IDW-1:0] ptr_next;
    assign ptr_next = (ev_id_reg == IDW'(N_BTN - 1)) ? '0 : ev_id_reg + IDW'(1);

    // ------------------------------------------------------------------
    // Offer FSM. Leaving OFFER always passes through IDLE, which yields
    // the mandatory low cycle between consecutive events.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg    <= IDLE;
            ev_valid_reg <= 1'b0;
            ev_id_reg    <= '0;
            ptr_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_grant) begin
                        ev_id_reg    <= grant;
                        ev_valid_reg <= 1'b1;
                        state_reg    <= OFFER;
                    end
                end
                OFFER: begin
                    if (EV_READY) begin
                        ev_valid_reg <= 1'b0;
                        ptr_reg      <= ptr_next;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    ev_valid_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign EV_VALID = ev_valid_reg;
    assign EV_ID    = ev_id_reg;

endmodule

// File: tb/tb_btn_event_sched.sv
// -----------------------------------------------------------------------------
// tb_btn_event_sched
//
// Directed scenarios followed by random traffic. A behavioural model updated
// on each rising edge keeps pending presses as a boolean array, picks the
// next event by scanning from the round-robin pointer with modulo arithmetic,
// and pushes the expected event index into a queue. A monitor on the falling
// edge compares CE_O, OVF, EV_VALID and EV_ID, popping the queue on each
// accepted event.
// -----------------------------------------------------------------------------
module tb_btn_event_sched;

    localparam int N     = 4;
    localparam int PRESC = 5;
    localparam int IDW   = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           ce;
    logic [N-1:0]   btn_ev;
    logic           ev_valid;
    logic [IDW-1:0] ev_id;
    logic           ev_ready;
    logic [N-1:0]   ovf;
    logic           ovf_clr;

    always #5 clk = ~clk;

    btn_event_sched #(
        .N_BTN (N),
        .PRESC (PRESC),
        .IDW   (IDW)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .CE_O     (ce),
        .BTN_EV   (btn_ev),
        .EV_VALID (ev_valid),
        .EV_ID    (ev_id),
        .EV_READY (ev_ready),
        .OVF      (ovf),
        .OVF_CLR  (ovf_clr)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model state ----------------
    bit m_pend [N];
    bit m_ovf  [N];
    int m_ptr;
    bit m_offer;
    int m_id;
    int m_k;          // rising edges since reset release
    bit m_ce;
    bit m_init = 1'b0;
    bit m_in_rst;
    int exp_q [$];

    always @(posedge clk) begin : model
        bit old_pend [N];
        bit hs;
        bit clr;
        bit found;
        int j;
        m_init = 1'b1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end
            m_ptr    = 0;
            m_offer  = 1'b0;
            m_id     = 0;
            m_k      = 0;
            m_ce     = 1'b0;
            m_in_rst = 1'b1;
            exp_q.delete();
        end else begin
            m_in_rst = 1'b0;
            m_k      = m_k + 1;
            m_ce     = ((m_k % PRESC) == 0);
            hs       = m_offer && ev_ready;
            old_pend = m_pend;
            for (int i = 0; i < N; i++) begin
                clr = hs && (m_id == i);
                if (btn_ev[i] && old_pend[i] && !clr) m_ovf[i] = 1'b1;
                else if (ovf_clr)                      m_ovf[i] = 1'b0;
                m_pend[i] = btn_ev[i] || (old_pend[i] && !clr);
            end
            if (m_offer) begin
                if (ev_ready) begin
                    m_offer = 1'b0;
                    m_ptr   = (m_id + 1) % N;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && old_pend[j]) begin
                        found   = 1'b1;
                        m_offer = 1'b1;
                        m_id    = j;
                        exp_q.push_back(j);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        int exp_ovf;
        if (m_init) begin
            exp_ovf = 0;
            for (int i = 0; i < N; i++) exp_ovf |= (int'(m_ovf[i]) << i);
            check("ce_o", int'(ce), int'(m_ce));
            check("ovf", int'(ovf), exp_ovf);
            check("ev_valid", int'(ev_valid), int'(m_offer));
            if (m_in_rst) check("ev_id_reset", int'(ev_id), 0);
            if (ev_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ev_id at %0t: got %0d, expected no event", $time, ev_id);
                end else begin
                    check("ev_id", int'(ev_id), exp_q[0]);
                    if (ev_ready) begin
                        $display("event accepted: id=%0d at %0t", ev_id, $time);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [N-1:0] b, input logic r, input logic oc, input logic rs);
        btn_ev   = b;
        ev_ready = r;
        ovf_clr  = oc;
        rst      = rs;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc('0, r, 1'b0, 1'b1);
    endtask

    initial begin
        btn_ev   = '0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        rst      = 1'b0;

        // reset held three cycles, then prescaler free-runs
        for (int i = 0; i < 3; i++) cyc('0, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b1);

        // single press on channel 2
        cyc(4'b0100, 1'b1, 1'b0, 1'b1);
        idle(5, 1'b1);

        // round robin over all channels, then wrap back to 0
        cyc(4'b1111, 1'b1, 1'b0, 1'b1);
        idle(10, 1'b1);
        cyc(4'b1001, 1'b1, 1'b0, 1'b1);
        idle(6, 1'b1);

        // backpressure: channel 1 held, channel 3 arrives meanwhile
        cyc(4'b0010, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b0);
        idle(6, 1'b1);

        // overflow on channel 0 while its event is held
        cyc(4'b0001, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0, 1'b1);
        cyc(4'b0001, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);
        cyc('0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        // new overflow coinciding with OVF_CLR keeps the flag
        cyc(4'b0001, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        cyc(4'b0001, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1);
        cyc('0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // press on channel 2 in the handshake cycle of event 2
        cyc(4'b0100, 1'b1, 1'b0, 1'b1);
        cyc('0, 1'b1, 1'b0, 1'b1);
        cyc(4'b0100, 1'b1, 1'b0, 1'b1);
        idle(6, 1'b1);

        // reset while an event is offered
        cyc(4'b0010, 1'b0, 1'b0, 1'b1);
        cyc(4'b0100, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        cyc('0, 1'b0, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] b;
            b = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            cyc(b, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 299) != 0));
        end
        idle(12, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
